// File: rtl/uart_frame_rx.sv
// Receive-side framer: hunts for SOF, captures a length-prefixed payload, verifies the
// additive checksum and replays only verified payloads on the AXI4-Stream master port.
module uart_frame_rx #(
   parameter int unsigned MAX_LEN = 16,
   parameter logic [7:0]  SOF     = 8'h7E,
   parameter int unsigned TIMEOUT = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,
   output logic       m_axis_tlast,
   output logic       busy,
   output logic       frame_ok,
   output logic       checksum_error,
   output logic       length_error,
   output logic       timeout_error
);

   localparam int unsigned IW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [7:0]  MAX_LEN8 = 8'(MAX_LEN);
   localparam logic [23:0] TO_LAST  = 24'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_HUNT,
      S_LEN,
      S_PAYLOAD,
      S_CHK,
      S_SEND
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  len_q;
   logic [7:0]  idx;
   logic [7:0]  sum;
   logic [23:0] cnt;
   logic [7:0]  mem [2**IW];

   logic accept, in_frame, last_idx, len_bad, chk_pass, timeout_hit;
   logic ok_nxt, chk_err_nxt, len_err_nxt, to_err_nxt;

   // Ready is a pure state decode, so accept is derived from state to avoid a comb loop.
   assign accept      = s_axis_tvalid && (state != S_SEND);
   assign in_frame    = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
   assign last_idx    = (idx == len_q - 8'd1);
   assign len_bad     = (s_axis_tdata == 8'd0) || (s_axis_tdata > MAX_LEN8);
   assign chk_pass    = (8'(sum + s_axis_tdata) == 8'd0);
   // An accept on the edge where the counter would reach TIMEOUT suppresses the timeout.
   assign timeout_hit = (TIMEOUT != 0) && in_frame && !accept && (cnt == TO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_HUNT;
         frame_ok       <= 1'b0;
         checksum_error <= 1'b0;
         length_error   <= 1'b0;
         timeout_error  <= 1'b0;
      end else begin
         state          <= state_nxt;
         frame_ok       <= ok_nxt;
         checksum_error <= chk_err_nxt;
         length_error   <= len_err_nxt;
         timeout_error  <= to_err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_HUNT:    if (accept && s_axis_tdata == SOF) state_nxt = S_LEN;
         S_LEN: begin
            if (accept)           state_nxt = len_bad ? S_HUNT : S_PAYLOAD;
            else if (timeout_hit) state_nxt = S_HUNT;
         end
         S_PAYLOAD: begin
            if (accept && last_idx) state_nxt = S_CHK;
            else if (timeout_hit)   state_nxt = S_HUNT;
         end
         S_CHK: begin
            if (accept)           state_nxt = chk_pass ? S_SEND : S_HUNT;
            else if (timeout_hit) state_nxt = S_HUNT;
         end
         S_SEND:    if (m_axis_tready && last_idx) state_nxt = S_HUNT;
         default:   state_nxt = S_HUNT;
      endcase
   end

   always_comb begin
      s_axis_tready = (state != S_SEND);
      busy          = (state != S_HUNT);
      m_axis_tvalid = (state == S_SEND);
      m_axis_tlast  = (state == S_SEND) && last_idx;
      m_axis_tdata  = (state == S_SEND) ? mem[idx[IW-1:0]] : '0;
      ok_nxt        = (state == S_CHK) && accept && chk_pass;
      chk_err_nxt   = (state == S_CHK) && accept && !chk_pass;
      len_err_nxt   = (state == S_LEN) && accept && len_bad;
      to_err_nxt    = timeout_hit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q <= '0;
         idx   <= '0;
         sum   <= '0;
         cnt   <= '0;
      end else begin
         if (accept || !in_frame) cnt <= '0;
         else                     cnt <= cnt + 24'd1;
         case (state)
            S_LEN: if (accept) begin
               len_q <= s_axis_tdata;
               sum   <= s_axis_tdata;
               idx   <= '0;
            end
            S_PAYLOAD: if (accept) begin
               sum <= sum + s_axis_tdata;
               idx <= idx + 8'd1;
            end
            S_CHK:  if (accept) idx <= '0;
            S_SEND: if (m_axis_tready) idx <= idx + 8'd1;
            default: ;
         endcase
      end
   end

   // Payload buffer needs no reset: contents are only read in SEND after being written.
   always_ff @(posedge clk) begin
      if (state == S_PAYLOAD && accept) mem[idx[IW-1:0]] <= s_axis_tdata;
   end

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Receive-side framer that sits directly downstream of the UART receiver. It consumes the byte stream on an AXI4-Stream slave port and hunts for a start-of-frame byte. It then captures a length-prefixed payload into an internal buffer and verifies an 8-bit additive checksum. Only verified payloads are replayed on an AXI4-Stream master port, with `tlast` on the final byte, so host logic only ever sees complete, checked frames.

## Interface
- `MAX_LEN`, 16: maximum payload bytes per frame (1..255); sets buffer depth.
- `SOF`, 8'h7E: start-of-frame byte value.
- `TIMEOUT`, 100000: inter-byte timeout in clk cycles while inside a frame; 0 disables; max 2^24-1.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `s_axis_tdata`  in  8  received byte from UART receiver.
- `s_axis_tvalid`  in  1  byte valid.
- `s_axis_tready`  out  1  framer can accept a byte.
- `m_axis_tdata`  out  8  verified payload byte.
- `m_axis_tvalid`  out  1  payload byte valid.
- `m_axis_tready`  in  1  downstream accepts byte.
- `m_axis_tlast`  out  1  last payload byte of the frame.
- `busy`  out  1  high in any state other than HUNT.
- `frame_ok`  out  1  one-cycle pulse: frame passed checksum.
- `checksum_error`  out  1  one-cycle pulse: checksum mismatch, frame dropped.
- `length_error`  out  1  one-cycle pulse: LEN = 0 or LEN > MAX_LEN, frame dropped.
- `timeout_error`  out  1  one-cycle pulse: inter-byte timeout, frame dropped.

## Operation
- Frame format: SOF, LEN, LEN payload bytes, CHK. Valid when (LEN + Σpayload + CHK) mod 256 == 0.
- Accept means `s_axis_tvalid && s_axis_tready` on a rising edge.
- States: HUNT, LEN, PAYLOAD, CHK, SEND.
- HUNT:
  - Accepted byte == SOF → LEN.
  - Any other byte is discarded silently.
- LEN:
  - Accepted byte of 0 or > MAX_LEN → `length_error`, go to HUNT.
  - Otherwise latch LEN, sum = LEN, index = 0, go to PAYLOAD.
- PAYLOAD:
  - Each accepted byte is written to buf[index], sum += byte (8-bit wrap), index++.
  - After byte LEN-1 is accepted → CHK.
  - SOF bytes inside the payload are ordinary data; there is no escaping.
- CHK:
  - Accepted byte: if (sum + byte) mod 256 == 0 → `frame_ok`, index = 0, go to SEND.
  - Else → `checksum_error`, go to HUNT.
- SEND:
  - `m_axis_tvalid` = 1 and `m_axis_tdata` = buf[index].
  - `m_axis_tlast` = (index == LEN-1).
  - On `m_axis_tready` index advances; handshake on the last byte → HUNT.
- `s_axis_tready` = 1 in HUNT/LEN/PAYLOAD/CHK and 0 in SEND. The upstream receiver holds the byte or flags overrun; the framer never drops an offered byte.
- Timeout:
  - A counter clears on every accept and in HUNT/SEND, and increments each cycle in LEN/PAYLOAD/CHK.
  - Reaching TIMEOUT → `timeout_error`, go to HUNT.
  - If an accept occurs in the same cycle the counter reaches TIMEOUT, the accept wins and there is no timeout.
- Error pulses are mutually exclusive and last exactly one cycle.
- Buffer contents are don't-care outside SEND.

## Timing
- Reset (async assert, sync release): state HUNT. Outputs `m_axis_tvalid`, `m_axis_tlast`, `busy`, and all pulse outputs are 0. `m_axis_tdata` = 0 and `s_axis_tready` = 1. Counters and sum are 0.
- Reset mid-frame or mid-SEND aborts immediately. Partial frames are never output.
- All status outputs are registered. A pulse is asserted in the cycle after the triggering accept or timeout edge.
- CHK accepted at edge N → `frame_ok` = 1 and `m_axis_tvalid` = 1 with buf[0] in cycle N+1.
- Master data is stable while `m_axis_tvalid` && !`m_axis_tready`. At full throughput `m_axis_tready` = 1 gives one byte per cycle, and a frame drains in LEN cycles.
- Last SEND handshake at edge M → HUNT, with `s_axis_tready` = 1 and `busy` = 0 in cycle M+1.
- `busy` rises the cycle after SOF is accepted.
- Minimum frame spacing: SOF accepted in back-to-back cycles after the previous frame drains.

## Test plan
- Input 7E 03 11 22 33 97 with `m_axis_tready` = 1 → `frame_ok` pulse; output 11, 22, 33 on consecutive cycles, `tlast` only on 33; `busy` low afterwards.
- Input 7E 03 11 22 33 98 → `checksum_error` pulse, no `m_axis_tvalid`. A following valid frame 7E 01 7E 81 outputs single byte 7E with `tlast`.
- Input 55 AA 7E 00 and, separately, 7E 11 (with MAX_LEN = 16) → junk bytes ignored; `length_error` pulse in each case; back to HUNT.
- Input 7E 02 AB then idle with TIMEOUT = 50 → `timeout_error` exactly 50 cycles after the AB accept; a late byte is ignored unless it is SOF.
- Valid 4-byte frame with `m_axis_tready` toggled randomly → data held stable while stalled; `s_axis_tready` stays 0 during SEND; byte order and `tlast` are preserved.
- Deassert `rst_n` mid-PAYLOAD and again mid-SEND → all outputs reset immediately; no partial frame after release.
